// File: rtl/final_fpga_timer_pkg.sv
// Shared register indices, bit positions and reset defaults for the multi-channel timer.
package final_fpga_timer_pkg;
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAPSHOT = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;
  localparam logic [2:0] REG_COMPARE  = 3'd5;
  localparam logic [2:0] REG_IRQPEND  = 3'd6;

  localparam int STS_TO    = 0;
  localparam int STS_RUN   = 1;
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam logic [31:0] RESET_PERIOD_DEF = 32'h0001_869F;
endpackage

// File: rtl/final_fpga_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags, snapshot and register read mux.
// Optional COMPARE register and registered PWM output when TIMER_PWM_EN is defined.
module final_fpga_timer_channel
  import final_fpga_timer_pkg::*;
#(
  parameter int               CNT_W        = 32,
  parameter int               PRE_W        = 16,
  parameter int               DATA_W       = 32,
  parameter logic [CNT_W-1:0] RESET_PERIOD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr_status,
  input  logic              i_wr_control,
  input  logic              i_wr_period,
  input  logic              i_wr_snapshot,
  input  logic              i_wr_prescale,
`ifdef TIMER_PWM_EN
  input  logic              i_wr_compare,
`endif
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [2:0]        i_rd_idx,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_irq_pend,
  output logic              o_pwm
);
  logic [CNT_W-1:0] r_cnt, r_period, r_snap;
  logic [PRE_W-1:0] r_prescale, r_pre_act, r_pre_cnt;
  logic             r_run, r_to, r_ito, r_cont;
  logic             w_start, w_stop, w_tick, w_evt;

  // A PERIOD write outranks START; a START cycle never advances the counter.
  assign w_start = i_wr_control & i_wdata[CTL_START] & ~i_wr_period;
  assign w_stop  = i_wr_control & i_wdata[CTL_STOP];
  assign w_tick  = r_run & (r_pre_cnt == r_pre_act) & ~w_start & ~i_wr_period;
  assign w_evt   = w_tick & (r_cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= RESET_PERIOD;
      r_period   <= RESET_PERIOD;
      r_snap     <= '0;
      r_prescale <= '0;
      r_pre_act  <= '0;
      r_pre_cnt  <= '0;
      r_run      <= 1'b0;
      r_to       <= 1'b0;
      r_ito      <= 1'b0;
      r_cont     <= 1'b0;
    end else begin
      if (i_wr_period | w_start | w_tick) r_pre_cnt <= '0;
      else if (r_run)                     r_pre_cnt <= r_pre_cnt + PRE_W'(1);

      // Active prescale is latched so a smaller new value cannot be skipped past.
      if (w_start | w_tick) r_pre_act <= r_prescale;

      if (i_wr_period) begin
        r_period <= i_wdata[CNT_W-1:0];
        r_cnt    <= i_wdata[CNT_W-1:0];
      end else if (w_evt) begin
        r_cnt <= r_period;
      end else if (w_tick) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (i_wr_period)                    r_run <= 1'b0;
      else if (w_start)                   r_run <= 1'b1;
      else if (w_stop | (w_evt & ~r_cont)) r_run <= 1'b0;

      if (w_evt)            r_to <= 1'b1;
      else if (i_wr_status) r_to <= 1'b0;

      if (i_wr_control) begin
        r_ito  <= i_wdata[CTL_ITO];
        r_cont <= i_wdata[CTL_CONT];
      end
      if (i_wr_prescale) r_prescale <= i_wdata[PRE_W-1:0];
      if (i_wr_snapshot) r_snap     <= r_cnt;
    end
  end

`ifdef TIMER_PWM_EN
  logic [CNT_W-1:0] r_compare;
  logic             r_pwm;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_compare <= '0;
      r_pwm     <= 1'b0;
    end else begin
      if (i_wr_compare) r_compare <= i_wdata[CNT_W-1:0];
      r_pwm <= r_run & (r_cnt <= r_compare);
    end
  end
  assign o_pwm = r_pwm;
`else
  assign o_pwm = 1'b0;
`endif

  assign o_irq_pend = r_to & r_ito;

  always_comb begin
    o_rdata = '0;
    case (i_rd_idx)
      REG_STATUS: begin
        o_rdata[STS_TO]  = r_to;
        o_rdata[STS_RUN] = r_run;
      end
      REG_CONTROL: begin
        o_rdata[CTL_ITO]  = r_ito;
        o_rdata[CTL_CONT] = r_cont;
      end
      REG_PERIOD:   o_rdata[CNT_W-1:0] = r_period;
      REG_SNAPSHOT: o_rdata[CNT_W-1:0] = r_snap;
      REG_PRESCALE: o_rdata[PRE_W-1:0] = r_prescale;
`ifdef TIMER_PWM_EN
      REG_COMPARE:  o_rdata[CNT_W-1:0] = r_compare;
`else
      REG_COMPARE:  o_rdata = '0;
`endif
      default:      o_rdata = '0;
    endcase
  end
endmodule

// File: rtl/final_fpga_multi_timer.sv
// NUM_CH-channel interval timer on an Avalon-MM slave: decode, per-channel strobes, read mux, irq OR.
// Define TIMER_PWM_EN to add a COMPARE register and PWM output per channel.
module final_fpga_multi_timer
  import final_fpga_timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 16,
  parameter logic [31:0] RESET_PERIOD = RESET_PERIOD_DEF,
  parameter int          DATA_W       = 32,
  localparam int         ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   w_ch;
  logic [2:0]        w_idx;
  logic              w_wr;
  logic [NUM_CH-1:0] w_pend;
  logic [DATA_W-1:0] w_ch_rdata [NUM_CH];
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] r_readdata;

  assign w_idx = address[2:0];
  assign w_wr  = chipselect & ~write_n;

  generate
    if (NUM_CH > 1) begin : g_multi
      assign w_ch = address[ADDR_W-1:3];
    end else begin : g_single
      assign w_ch = '0;
    end
  endgenerate

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_hit;
    assign w_hit = w_wr & (w_ch == CH_W'(gi));

    final_fpga_timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .DATA_W       (DATA_W),
      .RESET_PERIOD (RESET_PERIOD[CNT_W-1:0])
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_wr_status   (w_hit & (w_idx == REG_STATUS)),
      .i_wr_control  (w_hit & (w_idx == REG_CONTROL)),
      .i_wr_period   (w_hit & (w_idx == REG_PERIOD)),
      .i_wr_snapshot (w_hit & (w_idx == REG_SNAPSHOT)),
      .i_wr_prescale (w_hit & (w_idx == REG_PRESCALE)),
`ifdef TIMER_PWM_EN
      .i_wr_compare  (w_hit & (w_idx == REG_COMPARE)),
`endif
      .i_wdata       (writedata),
      .i_rd_idx      (w_idx),
      .o_rdata       (w_ch_rdata[gi]),
      .o_irq_pend    (w_pend[gi]),
      .o_pwm         (pwm_out[gi])
    );
  end

  // IRQPEND is global, so it answers at index 6 of any channel.
  always_comb begin
    w_rd = '0;
    if (w_idx == REG_IRQPEND) begin
      w_rd = DATA_W'(w_pend);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch == CH_W'(c)) w_rd = w_ch_rdata[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd;
  end

  assign readdata = r_readdata;
  assign irq      = |w_pend;
endmodule

// File: tb/tb_final_fpga_multi_timer.sv
// Self-checking bench for final_fpga_multi_timer; expectations come from interval arithmetic and a register model.
module tb_final_fpga_multi_timer;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] pwm_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  final_fpga_multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // All bus tasks start and end just after a falling edge.
  task automatic bus_write(input int ch, input int idx, input logic [31:0] data);
    address = ADDR_W'((ch << 3) | idx);
    chipselect = 1'b1; write_n = 1'b0; writedata = data;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int idx, output logic [31:0] data);
    address = ADDR_W'((ch << 3) | idx);
    chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    data = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_irq(input int limit, output int at, output bit ok);
    int n = 0;
    while (irq !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = (irq === 1'b1);
    at = cyc;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp_v;
    bit seen;
    repeat (3) @(negedge clk);
    checks++;
    if ({readdata, irq, pwm_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%h irq=%b pwm=%b expected all 0", readdata, irq, pwm_out);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_read(0, i, d);
      exp_v = (i == 2) ? 32'h0001_869F : 32'h0;
      checks++;
      if (d !== exp_v) begin
        errors++;
        $display("FAIL reset_reg idx%0d: got %h expected %h", i, d, exp_v);
      end
    end
    for (int c = 1; c < NUM_CH; c++) begin
      bus_read(c, 2, d);
      checks++;
      if (d !== 32'h0001_869F) begin
        errors++;
        $display("FAIL reset_period ch%0d: got %h expected 0001869f", c, d);
      end
    end
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (irq !== 1'b0) seen = 1'b1;
    end
    bus_read(0, 0, d);
    checks++;
    if (seen || d !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle: got irq_seen=%b status=%h expected 0 0", seen, d);
    end
  endtask

  task automatic test_regs();
    logic [31:0] exp_period [NUM_CH];
    logic [15:0] exp_pre [NUM_CH];
    logic [1:0]  exp_ctl [NUM_CH];
    logic [31:0] exp_cmp [NUM_CH];
    logic [31:0] d, e;
    int ch, k;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_period[c] = 32'h0001_869F; exp_pre[c] = '0; exp_ctl[c] = '0; exp_cmp[c] = '0;
    end
    for (int n = 0; n < 24; n++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      k  = $urandom_range(0, 4);
      d  = $urandom;
      case (k)
        0: begin bus_write(ch, 2, d); exp_period[ch] = d; end
        1: begin bus_write(ch, 4, d); exp_pre[ch] = d[15:0]; end
        2: begin d = d & ~32'hC; bus_write(ch, 1, d); exp_ctl[ch] = d[1:0]; end
        3: begin
          bus_write(ch, 5, d);
`ifdef TIMER_PWM_EN
          exp_cmp[ch] = d;
`endif
        end
        default: bus_write(ch, 7, d);
      endcase
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < 8; i++) begin
        bus_read(c, i, d);
        case (i)
          1: e = {30'h0, exp_ctl[c]};
          2: e = exp_period[c];
          4: e = {16'h0, exp_pre[c]};
          5: e = exp_cmp[c];
          default: e = 32'h0;
        endcase
        checks++;
        if (d !== e) begin
          errors++;
          $display("FAIL regs ch%0d idx%0d: got %h expected %h", c, i, d, e);
        end
      end
      bus_write(c, 1, 32'h0);
    end
  endtask

  task automatic run_cont(input int ch, input int p, input int s, input bit rd_status);
    int start, iv, at;
    bit ok;
    logic [31:0] d;
    bus_write(ch, 2, 32'(p));
    bus_write(ch, 4, 32'(s));
    bus_write(ch, 1, 32'h7);
    start = cyc;
    iv = (p + 1) * (s + 1);
    for (int k = 1; k <= 3; k++) begin
      wait_irq(iv + 10, at, ok);
      checks++;
      if (!ok || at != start + k * iv) begin
        errors++;
        $display("FAIL cont_evt ch%0d P%0d S%0d n%0d: got cyc %0d (irq %b) expected %0d",
                 ch, p, s, k, at - start, ok, k * iv);
      end
      if (rd_status && k == 1) begin
        bus_read(ch, 0, d);
        checks++;
        if (d !== 32'h3) begin
          errors++;
          $display("FAIL cont_status ch%0d: got %h expected 00000003", ch, d);
        end
      end
      bus_write(ch, 0, 32'h0);
      checks++;
      if (irq !== 1'b0) begin
        errors++;
        $display("FAIL cont_clear ch%0d: got irq %b expected 0", ch, irq);
      end
    end
    bus_write(ch, 1, 32'h8);
    bus_write(ch, 0, 32'h0);
    bus_read(ch, 0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL cont_stop ch%0d: got %h expected 00000000", ch, d);
    end
  endtask

  task automatic test_continuous();
    int p, s;
    run_cont(1, 9, 1, 1'b1);
    for (int n = 0; n < 3; n++) begin
      s = $urandom_range(0, 3);
      p = $urandom_range(1, 12);
      if ((p + 1) * (s + 1) < 8) p = 7;
      run_cont($urandom_range(0, NUM_CH - 1), p, s, 1'b0);
    end
  endtask

  task automatic run_oneshot(input int ch, input int p, input int s);
    int start, iv, at;
    bit ok, seen;
    logic [31:0] d, e;
    bus_write(ch, 2, 32'(p));
    bus_write(ch, 4, 32'(s));
    bus_write(ch, 1, 32'h5);
    start = cyc;
    iv = (p + 1) * (s + 1);
    wait_irq(iv + 10, at, ok);
    checks++;
    if (!ok || at != start + iv) begin
      errors++;
      $display("FAIL oneshot_evt ch%0d: got cyc %0d (irq %b) expected %0d", ch, at - start, ok, iv);
    end
    bus_read(ch, 0, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL oneshot_status ch%0d: got %h expected 00000001", ch, d);
    end
    e = 32'(1) << ch;
    bus_read(ch, 6, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL irqpend_own ch%0d: got %h expected %h", ch, d, e);
    end
    bus_read((ch + 1) % NUM_CH, 6, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL irqpend_other ch%0d: got %h expected %h", ch, d, e);
    end
    bus_write(ch, 0, 32'h0);
    seen = 1'b0;
    if (irq !== 1'b0) seen = 1'b1;
    repeat (3 * iv) begin
      @(negedge clk);
      if (irq !== 1'b0) seen = 1'b1;
    end
    bus_read(ch, 0, d);
    checks++;
    if (seen || d !== 32'h0) begin
      errors++;
      $display("FAIL oneshot_after ch%0d: got irq_seen=%b status=%h expected 0 0", ch, seen, d);
    end
    bus_write(ch, 1, 32'h0);
  endtask

  task automatic test_oneshot();
    int p, s;
    run_oneshot(2, 4, 0);
    for (int n = 0; n < 2; n++) begin
      s = $urandom_range(0, 2);
      p = $urandom_range(1, 10);
      if ((p + 1) * (s + 1) < 6) p = 5;
      run_oneshot($urandom_range(0, NUM_CH - 1), p, s);
    end
  endtask

  task automatic test_collisions();
    int start;
    logic [31:0] d, pn;
    bus_write(3, 2, 32'd7);
    bus_write(3, 4, 32'd0);
    bus_write(3, 1, 32'h7);
    start = cyc;
    while (cyc < start + 7) @(negedge clk);
    bus_write(3, 0, 32'h0);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL status_vs_evt: got irq %b expected 1", irq);
    end
    bus_write(3, 1, 32'h8);
    bus_write(3, 0, 32'h0);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL status_vs_evt_clear: got irq %b expected 0", irq);
    end

    bus_write(0, 4, 32'd0);
    bus_write(0, 2, 32'd1000);
    bus_write(0, 0, 32'h0);
    bus_write(0, 1, 32'hC);
    bus_read(0, 0, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL start_stop_status: got %h expected 00000002", d);
    end
    bus_read(0, 1, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL start_stop_control: got %h expected 00000000", d);
    end
    repeat (5) @(negedge clk);
    pn = 32'($urandom_range(1, 16'hFFFF));
    bus_write(0, 2, pn);
    bus_write(0, 3, 32'h0);
    bus_read(0, 0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL period_stop_status: got %h expected 00000000", d);
    end
    bus_read(0, 3, d);
    checks++;
    if (d !== pn) begin
      errors++;
      $display("FAIL period_reload_cnt: got %h expected %h", d, pn);
    end
  endtask

  task automatic test_snapshot();
    int start, cap;
    logic [31:0] d, e;
    bus_write(0, 4, 32'd0);
    bus_write(0, 2, 32'h2000);
    bus_write(0, 1, 32'h6);
    start = cyc;
    while (cyc < start + 3532) @(negedge clk);
    bus_write(0, 3, 32'hDEAD_BEEF);
    bus_read(0, 3, d);
    checks++;
    if (d !== 32'h1234) begin
      errors++;
      $display("FAIL snapshot_1234: got %h expected 00001234", d);
    end
    bus_read(0, 0, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL snapshot_running: got %h expected 00000002", d);
    end
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(5, 50)) @(negedge clk);
      cap = cyc + 1;
      bus_write(0, 3, $urandom);
      bus_read(0, 3, d);
      e = 32'(32'h2000 - (cap - start - 1));
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL snapshot_rand n%0d: got %h expected %h", n, d, e);
      end
    end
    // Restarting a running channel must skip exactly one decrement.
    bus_write(0, 1, 32'h6);
    repeat ($urandom_range(3, 30)) @(negedge clk);
    cap = cyc + 1;
    bus_write(0, 3, 32'h0);
    bus_read(0, 3, d);
    e = 32'(32'h2000 - (cap - start - 1) + 1);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL start_while_run: got %h expected %h", d, e);
    end
  endtask

  task automatic test_async_reset();
    int at;
    bit ok;
    logic [31:0] d;
    bus_write(1, 4, 32'd0);
    bus_write(1, 2, 32'd2);
    bus_write(1, 1, 32'h5);
    wait_irq(20, at, ok);
    bus_read(0, 2, d);
    checks++;
    if (!ok || d !== 32'h2000) begin
      errors++;
      $display("FAIL prereset: got irq %b period %h expected 1 00002000", ok, d);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({readdata, irq, pwm_out} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rd=%h irq=%b pwm=%b expected all 0", readdata, irq, pwm_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(0, 2, d);
    checks++;
    if (d !== 32'h0001_869F) begin
      errors++;
      $display("FAIL postreset_period: got %h expected 0001869f", d);
    end
    repeat (200) @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      bus_read(c, 0, d);
      checks++;
      if (d !== 32'h0) begin
        errors++;
        $display("FAIL postreset_status ch%0d: got %h expected 00000000", c, d);
      end
    end
  endtask

  task automatic test_pwm();
    logic [31:0] d;
    int hi;
    logic [NUM_CH-1:0] other;
`ifdef TIMER_PWM_EN
    int cmp, e;
    for (int n = 0; n < 3; n++) begin
      cmp = (n == 0) ? 2 : $urandom_range(0, 12);
      bus_write(0, 4, 32'd0);
      bus_write(0, 2, 32'd9);
      bus_write(0, 5, 32'(cmp));
      bus_write(0, 1, 32'h6);
      repeat (12) @(negedge clk);
      hi = 0; other = '0;
      repeat (20) begin
        @(negedge clk);
        hi += int'(pwm_out[0]);
        other |= pwm_out & ~NUM_CH'(1);
      end
      e = 2 * (((cmp > 9) ? 9 : cmp) + 1);
      checks++;
      if (hi != e || other !== '0) begin
        errors++;
        $display("FAIL pwm_duty cmp%0d: got %0d/20 others %b expected %0d/20 others 0", cmp, hi, other, e);
      end
      bus_read(0, 5, d);
      checks++;
      if (d !== 32'(cmp)) begin
        errors++;
        $display("FAIL pwm_compare_rd: got %h expected %h", d, 32'(cmp));
      end
      bus_write(0, 1, 32'h8);
    end
`else
    bus_write(0, 4, 32'd0);
    bus_write(0, 2, 32'd9);
    bus_write(0, 5, $urandom | 32'h1);
    bus_write(0, 1, 32'h6);
    bus_read(0, 5, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL compare_absent: got %h expected 00000000", d);
    end
    hi = 0; other = '0;
    repeat (20) begin
      @(negedge clk);
      other |= pwm_out;
    end
    hi = int'(other != '0);
    checks++;
    if (hi != 0) begin
      errors++;
      $display("FAIL pwm_absent: got pwm %b expected 0", other);
    end
    bus_write(0, 1, 32'h8);
`endif
  endtask

  initial begin
    test_reset();
    test_regs();
    test_continuous();
    test_oneshot();
    test_collisions();
    test_snapshot();
    test_async_reset();
    test_pwm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
